// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, grant encodings and timeout defaults for mem_arbiter
package mem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CPU  = 2'd1;
  localparam state_t S_DBG  = 2'd2;
  localparam state_t S_REC  = 2'd3;
  localparam logic G_CPU = 1'b0;
  localparam logic G_DBG = 1'b1;
  localparam int TMO_DEFAULT = 15;
  function automatic int cnt_width(int tmo);
    return ($clog2(tmo + 1) < 4) ? 4 : $clog2(tmo + 1);
  endfunction
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: CPU, debug and shared memory port signals of mem_arbiter
interface mem_arb_if #(parameter int AW = 8, parameter int DW = 32);
  logic          cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, mem_ack, stall_mem;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_en, mem_we, mem_addr, mem_wdata, stall_mem
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_en, mem_we, mem_addr, mem_wdata, stall_mem
  );
endinterface

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: wait counter for an access; last flags the final cycle before the abort
module mem_arb_timeout import mem_arb_pkg::*; #(parameter int TMO = TMO_DEFAULT) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = cnt_width(TMO);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // a further ackless cycle here makes the count reach TMO
  assign last = cnt_q == CW'(TMO - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/debug arbiter for one shared memory port with access timeout
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int TMO = TMO_DEFAULT
) (
  input logic clk,
  input logic reset,
  mem_arb_if.master bus
);
  state_t state_q, state_d;
  logic lg_q, lg_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d, crd_q, crd_d, drd_q, drd_d;
  logic cack_q, cack_d, dack_q, dack_d, cerr_q, cerr_d, derr_q, derr_d;
  logic acc, own, go, pick, last;
  always_comb begin
    acc = state_q == S_CPU || state_q == S_DBG;
    own = state_q == S_DBG;
    // no grant while an ack is still visible to the requester holding req
    go = state_q == S_IDLE && !cack_q && !dack_q && (bus.cpu_req || bus.dbg_req);
    pick = bus.dbg_req && (!bus.cpu_req || lg_q == G_CPU);
    state_d = state_q;
    lg_d = lg_q;
    we_d = we_q;
    addr_d = addr_q;
    wd_d = wd_q;
    crd_d = crd_q;
    drd_d = drd_q;
    cack_d = 1'b0;
    dack_d = 1'b0;
    cerr_d = 1'b0;
    derr_d = 1'b0;
    if (go) begin
      state_d = pick ? S_DBG : S_CPU;
      we_d = pick ? bus.dbg_we : bus.cpu_we;
      addr_d = pick ? bus.dbg_addr : bus.cpu_addr;
      wd_d = pick ? bus.dbg_wdata : bus.cpu_wdata;
    end else if (acc && bus.mem_ack) begin
      state_d = S_IDLE;
      lg_d = own;
      cack_d = !own;
      dack_d = own;
      crd_d = (!own && !we_q) ? bus.mem_rdata : crd_q;
      drd_d = (own && !we_q) ? bus.mem_rdata : drd_q;
    end else if (acc && last) begin
      state_d = S_REC;
      cerr_d = !own;
      derr_d = own;
    end else if (state_q == S_REC) begin
      state_d = S_IDLE;
    end
  end
  mem_arb_timeout #(.TMO(TMO)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clr(go),
    .inc(acc && !bus.mem_ack),
    .last(last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      lg_q <= G_DBG;
      we_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      crd_q <= '0;
      drd_q <= '0;
      cack_q <= 1'b0;
      dack_q <= 1'b0;
      cerr_q <= 1'b0;
      derr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q <= lg_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      crd_q <= crd_d;
      drd_q <= drd_d;
      cack_q <= cack_d;
      dack_q <= dack_d;
      cerr_q <= cerr_d;
      derr_q <= derr_d;
    end
  assign bus.mem_en = acc;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wd_q;
  assign bus.stall_mem = own;
  assign bus.cpu_rdata = crd_q;
  assign bus.dbg_rdata = drd_q;
  assign bus.cpu_ack = cack_q;
  assign bus.dbg_ack = dack_q;
  assign bus.cpu_err = cerr_q;
  assign bus.dbg_err = derr_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8: memory word-address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TMO, default 15: cycles without mem_ack before a transaction is aborted.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Ports cpu_req / cpu_we  in  1 / 1  CPU access request and write enable.
REQ-007 Ports cpu_addr / cpu_wdata  in  AW / DW  CPU address and write data.
REQ-008 Ports cpu_rdata / cpu_ack / cpu_err  out  DW / 1 / 1  CPU read data, completion pulse and timeout pulse.
REQ-009 Ports dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1 / 1 / AW / DW  test/debug port request, write enable, address and write data.
REQ-010 Ports dbg_rdata / dbg_ack / dbg_err  out  DW / 1 / 1  debug read data, completion pulse and timeout pulse.
REQ-011 Ports mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  single shared memory port.
REQ-012 Ports mem_rdata / mem_ack  in  DW / 1  memory read data and completion.
REQ-013 Port stall_mem  out  1  high while the debug port owns memory, so the CPU pipeline freezes.

Function
REQ-014 The FSM SHALL have states IDLE, CPU_ACC, DBG_ACC and RECOVER.
REQ-015 IDLE, only cpu_req high: latch the CPU request into the command registers and go to CPU_ACC next cycle.
REQ-016 IDLE, only dbg_req high: latch the debug request into the command registers and go to DBG_ACC next cycle.
REQ-017 IDLE, both requests high: grant the requester that was not granted last (round-robin via a last_grant bit); after reset, CPU has priority.
REQ-018 In CPU_ACC/DBG_ACC: mem_en=1, and mem_we/addr/wdata are driven from the registers, stable until mem_ack.
REQ-019 On mem_ack in an ACC state: pulse the owner's ack for exactly 1 cycle, load its rdata from mem_rdata (only if read), update last_grant, go to IDLE.
REQ-020 Minimum latency SHALL be 2 cycles from req to ack when mem_ack returns in the first ACC cycle.
REQ-021 No grant SHALL be issued in the cycle an ack pulses; a back-to-back request is granted from IDLE the next cycle.
REQ-022 Requesters hold req, and their address/data/we, until their ack or err; req dropping mid-access SHALL NOT abort the access.
REQ-023 A 4-bit-minimum wait counter SHALL clear on entry to an ACC state and increment each ACC cycle without mem_ack.
REQ-024 When the counter reaches TMO: pulse the owner's err for 1 cycle, give no ack, leave rdata unchanged, deassert mem_en, go to RECOVER.
REQ-025 RECOVER SHALL last exactly 1 cycle with mem_en=0, then go to IDLE; any mem_ack seen in RECOVER or IDLE SHALL be ignored.
REQ-026 mem_ack arriving in the same cycle the counter hits TMO counts as success: ack, not err.
REQ-027 stall_mem SHALL be high in DBG_ACC and low in every other state.
REQ-028 cpu_rdata/dbg_rdata SHALL be registered and hold their last value between accesses.
REQ-029 Write accesses SHALL NOT modify rdata.

Reset
REQ-030 While reset is low: state=IDLE, last_grant=DBG (so CPU wins first tie), counter=0, and all outputs 0, including rdata, acks, errs, mem_* and stall_mem.
REQ-031 Reset asserted mid-access SHALL abandon the transaction with no ack or err, and mem_en SHALL drop asynchronously.

Structure
REQ-032 The FSM state encoding, the grant encoding (CPU=0, DBG=1) and the default TMO SHALL live in shared package mem_arb_pkg.
REQ-033 The block is one module with one natural sub-module, mem_arb_timeout, holding the wait counter and compare.
REQ-034 The block SHALL contain no memory arrays and no combinational path from mem_ack to any output.

Verification
REQ-035 CPU read of addr 0x10, mem_ack in the first ACC cycle -> cpu_ack at cycle 2, cpu_rdata=mem_rdata (e.g. 0xDEADBEEF), stall_mem stays 0.
REQ-036 cpu_req and dbg_req rise together three times -> grants are CPU, DBG, CPU; stall_mem high only during the DBG access.
REQ-037 Debug write 0x12345678 to 0xFF with mem_ack delayed 5 cycles -> mem_addr/mem_wdata stable for all 6 ACC cycles, one dbg_ack, dbg_rdata unchanged.
REQ-038 mem_ack never returns, TMO=15 -> cpu_err pulses once after 15 ACC cycles, then 1 RECOVER cycle, then IDLE; a late mem_ack is ignored.
REQ-039 reset pulled low 2 cycles into DBG_ACC -> all outputs go to 0 immediately; after release, a CPU request completes normally.
REQ-040 mem_ack coincides with counter=TMO -> ack, no err.
